cva6_bht_sat: RTL



---
 rtl/cva6_bht_sat.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cva6_bht_sat.sv
// Branch history table of 2-bit saturating counters with a one-stage update pipeline and a flush sweep.
// Optional macro CVA6_BHT_FWD_EN forwards the pending update write into the prediction path.
module cva6_bht_sat #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NR_ENTRIES = 128,
    parameter bit          CEXT_EN    = 1'b1,
    parameter logic [1:0]  INIT_CNT   = 2'b01
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    output logic            busy_o,
    input  logic [XLEN-1:0] vpc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic [1:0]      pred_cnt_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i
);

    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
    localparam int unsigned OFF   = CEXT_EN ? 1 : 2;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic [1:0]       cnt;
    } upd_t;

    logic [1:0]       cnt_q [NR_ENTRIES];
    state_e           state_q;
    logic [IDX_W-1:0] sweep_q;
    upd_t             upd_q;
    upd_t             upd_d;

    logic [IDX_W-1:0] vpc_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       cur_cnt;
    logic [1:0]       new_cnt;
    logic             unused_pc_bits;

    assign vpc_idx = vpc_i[OFF +: IDX_W];
    assign upd_idx = upd_pc_i[OFF +: IDX_W];

    // Upper PC bits only alias entries together; they never select anything.
    assign unused_pc_bits = ^{vpc_i[XLEN-1:OFF+IDX_W], vpc_i[OFF-1:0],
                              upd_pc_i[XLEN-1:OFF+IDX_W], upd_pc_i[OFF-1:0]};

    always_comb begin
        pred_cnt_o = cnt_q[vpc_idx];
`ifdef CVA6_BHT_FWD_EN
        if (upd_q.valid && (upd_q.idx == vpc_idx)) begin
            pred_cnt_o = upd_q.cnt;
        end
`endif
    end

    assign pred_taken_o = pred_cnt_o[1];
    assign busy_o       = (state_q == SWEEP);
    assign pred_valid_o = !busy_o;

    // The pending write has not reached the array yet, so a same-index update must start from it.
    always_comb begin
        cur_cnt = cnt_q[upd_idx];
        if (upd_q.valid && (upd_q.idx == upd_idx)) begin
            cur_cnt = upd_q.cnt;
        end
        new_cnt = cur_cnt;
        if (upd_taken_i) begin
            if (cur_cnt != 2'b11) begin
                new_cnt = cur_cnt + 2'b01;
            end
        end else begin
            if (cur_cnt != 2'b00) begin
                new_cnt = cur_cnt - 2'b01;
            end
        end
        upd_d.valid = upd_valid_i && (state_q == IDLE) && !flush_i;
        upd_d.idx   = upd_idx;
        upd_d.cnt   = new_cnt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                cnt_q[i] <= INIT_CNT;
            end
            state_q <= IDLE;
            sweep_q <= '0;
            upd_q   <= '0;
        end else begin
            upd_q <= upd_d;
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        state_q <= SWEEP;
                        sweep_q <= '0;
                    end else if (upd_q.valid) begin
                        cnt_q[upd_q.idx] <= upd_q.cnt;
                    end
                end
                SWEEP: begin
                    if (flush_i) begin
                        sweep_q <= '0;
                    end else begin
                        cnt_q[sweep_q] <= INIT_CNT;
                        sweep_q        <= sweep_q + 1'b1;
                        if (sweep_q == IDX_W'(NR_ENTRIES - 1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
